// File: rtl/pe_pkg.sv
// pe_pkg: shared weight-state encoding and default widths for the PE array.
package pe_pkg;
    typedef enum logic [1:0] {
        EMPTY         = 2'b00,
        SHADOW        = 2'b01,
        ACTIVE        = 2'b10,
        ACTIVE_SHADOW = 2'b11
    } pe_wstate_t;
    localparam int PE_DATA_W   = 8;
    localparam int PE_WEIGHT_W = 8;
    localparam int PE_ACC_W    = 32;
endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: signed ACC_W adder with overflow flag and optional clamp.
module pe_sat_add #(
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);
    logic [ACC_W:0] s;
    assign s     = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
    assign ovf_o = s[ACC_W] ^ s[ACC_W-1];
    // The extra sum bit holds the true sign, so it picks the clamp direction.
    assign sum_o = (SATURATE != 0 && ovf_o)
                 ? (s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                 : s[ACC_W-1:0];
endmodule

// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary PE with double-buffered weight and valid/switch propagation.
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int WEIGHT_W = PE_WEIGHT_W,
    parameter int ACC_W    = PE_ACC_W,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [DATA_W-1:0]   a_in,
    input  logic                       valid_in,
    input  logic                       switch_in,
    input  logic signed [ACC_W-1:0]    psum_in,
    input  logic signed [WEIGHT_W-1:0] w_in,
    input  logic                       w_load_in,
    output logic signed [DATA_W-1:0]   a_out,
    output logic                       valid_out,
    output logic                       switch_out,
    output logic signed [ACC_W-1:0]    psum_out,
    output logic signed [WEIGHT_W-1:0] w_out,
    output logic                       w_load_out,
    output logic                       ovf_out,
    output logic                       sw_err
);
    localparam int PW = DATA_W + WEIGHT_W;
    pe_wstate_t                 state_q, state_d;
    logic signed [WEIGHT_W-1:0] active_q, active_d, shadow_q, shadow_d, w_q, w_d;
    logic signed [DATA_W-1:0]   a_q, a_d;
    logic signed [ACC_W-1:0]    psum_q, psum_d, sum;
    logic signed [PW-1:0]       prod;
    logic                       valid_q, switch_q, wl_q, ovf_q, ovf_d, err_q, err_d;
    logic                       accept, ovf;
    pe_sat_add #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
        .a_i  (psum_in),
        .b_i  (ACC_W'(prod)),
        .sum_o(sum),
        .ovf_o(ovf)
    );
    always_comb begin
        accept   = switch_in & state_q[0];
        // The beat that carries an accepted switch already uses the promoted weight.
        active_d = accept ? shadow_q : active_q;
        prod     = PW'(a_in) * PW'(active_d);
        state_d  = pe_wstate_t'({state_q[1] | accept, w_load_in | (state_q[0] & ~accept)});
        shadow_d = w_load_in ? w_in : shadow_q;
        w_d      = w_load_in ? w_in : w_q;
        a_d      = valid_in ? a_in : a_q;
        psum_d   = valid_in ? sum : psum_q;
        ovf_d    = valid_in & ovf;
        err_d    = err_q | (switch_in & ~state_q[0]);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            active_q <= '0;
            shadow_q <= '0;
            w_q      <= '0;
            a_q      <= '0;
            psum_q   <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            wl_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            w_q      <= w_d;
            a_q      <= a_d;
            psum_q   <= psum_d;
            valid_q  <= valid_in;
            switch_q <= switch_in;
            wl_q     <= w_load_in;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end
    assign a_out      = a_q;
    assign valid_out  = valid_q;
    assign switch_out = switch_q;
    assign psum_out   = psum_q;
    assign w_out      = w_q;
    assign w_load_out = wl_q;
    assign ovf_out    = ovf_q;
    assign sw_err     = err_q;
endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb_pe_ws_dbuf: directed + random checks of three PE variants against a behavioural model.
module tb_pe_ws_dbuf;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rn, v, sw, wl;
    logic signed [7:0]  a, w;
    logic signed [31:0] p32;
    logic signed [15:0] p16;
    logic signed [7:0]  ao0, ao1, ao2, wo0, wo1, wo2;
    logic signed [31:0] po0;
    logic signed [15:0] po1, po2;
    logic vo0, vo1, vo2, so0, so1, so2, wlo0, wlo1, wlo2, ov0, ov1, ov2, er0, er1, er2;
    pe_ws_dbuf d0 (.clk(clk), .reset_n(rn), .a_in(a), .valid_in(v), .switch_in(sw), .psum_in(p32),
        .w_in(w), .w_load_in(wl), .a_out(ao0), .valid_out(vo0), .switch_out(so0), .psum_out(po0),
        .w_out(wo0), .w_load_out(wlo0), .ovf_out(ov0), .sw_err(er0));
    pe_ws_dbuf #(.ACC_W(16), .SATURATE(1)) d1 (.clk(clk), .reset_n(rn), .a_in(a), .valid_in(v),
        .switch_in(sw), .psum_in(p16), .w_in(w), .w_load_in(wl), .a_out(ao1), .valid_out(vo1),
        .switch_out(so1), .psum_out(po1), .w_out(wo1), .w_load_out(wlo1), .ovf_out(ov1), .sw_err(er1));
    pe_ws_dbuf #(.ACC_W(16), .SATURATE(0)) d2 (.clk(clk), .reset_n(rn), .a_in(a), .valid_in(v),
        .switch_in(sw), .psum_in(p16), .w_in(w), .w_load_in(wl), .a_out(ao2), .valid_out(vo2),
        .switch_out(so2), .psum_out(po2), .w_out(wo2), .w_load_out(wlo2), .ovf_out(ov2), .sw_err(er2));
    int checks = 0, errors = 0;
    int act, shd, e_a, e_w;
    bit shd_full, err, e_v, e_sw, e_wl;
    longint e_p[3];
    bit e_o[3];
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic bit oor(input longint x, input int n);
        return x > (longint'(1) <<< (n - 1)) - 1 || x < -(longint'(1) <<< (n - 1));
    endfunction
    function automatic longint wrapn(input longint x, input int n);
        longint m = longint'(1) <<< n;
        longint r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction
    function automatic longint satn(input longint x, input int n);
        longint mx = (longint'(1) <<< (n - 1)) - 1;
        return x > mx ? mx : (x < -mx - 1 ? -mx - 1 : x);
    endfunction
    task automatic model();
        bit acc;
        int we;
        longint f32, f16;
        if (!rn) begin
            act = 0; shd = 0; shd_full = 0; err = 0;
            e_a = 0; e_w = 0; e_v = 0; e_sw = 0; e_wl = 0;
            e_p = '{0, 0, 0}; e_o = '{0, 0, 0};
        end else begin
            acc = sw && shd_full;
            we = acc ? shd : act;
            if (sw && !shd_full) err = 1;
            e_sw = sw; e_wl = wl; e_v = v;
            if (wl) e_w = w;
            e_o = '{0, 0, 0};
            if (v) begin
                e_a = a;
                f32 = longint'(p32) + longint'(a) * longint'(we);
                f16 = longint'(p16) + longint'(a) * longint'(we);
                e_p[0] = wrapn(f32, 32); e_o[0] = oor(f32, 32);
                e_p[1] = satn(f16, 16);  e_o[1] = oor(f16, 16);
                e_p[2] = wrapn(f16, 16); e_o[2] = oor(f16, 16);
            end
            if (acc) act = shd;
            shd_full = wl || (shd_full && !acc);
            if (wl) shd = w;
        end
    endtask
    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("a_out", ao0, e_a);
        chk("valid_out", vo0, e_v);
        chk("switch_out", so0, e_sw);
        chk("w_out", wo0, e_w);
        chk("w_load_out", wlo0, e_wl);
        chk("sw_err", er0, err);
        chk("psum32", po0, e_p[0]);
        chk("ovf32", ov0, e_o[0]);
        chk("psum16sat", po1, e_p[1]);
        chk("ovf16sat", ov1, e_o[1]);
        chk("psum16wrap", po2, e_p[2]);
        chk("ovf16wrap", ov2, e_o[2]);
    endtask
    task automatic idle();
        v = 0; sw = 0; wl = 0; a = 0; w = 0; p32 = 0; p16 = 0;
    endtask
    task automatic rst();
        idle(); rn = 0; step(); rn = 1;
    endtask
    task automatic load(input int wv, input bit s);
        idle(); wl = 1; w = 8'(wv); step();
        if (s) begin idle(); sw = 1; step(); end
        idle();
    endtask
    initial begin
        rn = 1; idle();
        rst();
        load(9, 0);
        rn = 0; wl = 1; w = 5; v = 1; a = 3; p32 = 7; step();
        rn = 1; idle(); step();
        rst();
        load(-3, 0);
        wl = 1; w = -3; sw = 1; v = 1; a = 4; p32 = 10; p16 = 10; step();
        chk("t2_psum", po0, -2);
        rst();
        load(2, 1);
        for (int i = 1; i <= 3; i++) begin
            wl = (i == 1); w = 7; v = 1; a = 8'(i); p32 = 0; p16 = 0; step();
            chk("t3_stream", po0, 2 * i);
        end
        idle(); sw = 1; v = 1; a = 1; step();
        chk("t3_switch", po0, 7);
        rst();
        load(127, 1);
        v = 1; a = 127; p32 = 32000; p16 = 16'sd32000; step();
        chk("t4_sat", po1, 32767);
        chk("t4_ovf", ov1, 1);
        rst();
        load(4, 1);
        sw = 1; step();
        idle(); v = 1; a = 1; step();
        chk("t5_active", po0, 4);
        idle(); repeat (3) step();
        chk("t5_sticky", er0, 1);
        rst();
        load(-5, 1);
        v = 1; a = -7; p32 = 100; p16 = 100; step();
        idle(); repeat (3) step();
        for (int i = 0; i < 600; i++) begin
            rn = ($urandom_range(0, 99) >= 3);
            v = $urandom_range(0, 1);
            sw = ($urandom_range(0, 9) < 2);
            wl = ($urandom_range(0, 9) < 3);
            a = 8'($urandom);
            w = 8'($urandom);
            p16 = 16'($urandom);
            case ($urandom_range(0, 3))
                0: p32 = 32'h7fffffff - 32'($urandom_range(0, 20000));
                1: p32 = 32'h80000000 + 32'($urandom_range(0, 20000));
                default: p32 = 32'($urandom);
            endcase
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
